// File: rtl/snoop_bus_arbiter.sv
// Shared-bus controller for a snooping MSI system: round-robin grant, broadcast,
// snoop-ack collection, optional owner write-back and completion pulse.
module snoop_bus_arbiter #(
  parameter int N_CACHES = 4,
  parameter int ADDR_W   = 8,
  parameter int SRC_W    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_CACHES-1:0]        req,
  input  logic [2*N_CACHES-1:0]      req_op,
  input  logic [ADDR_W*N_CACHES-1:0] req_addr,
  input  logic [N_CACHES-1:0]        snoop_ack,
  input  logic [N_CACHES-1:0]        snoop_wb,
  input  logic                       wb_done,
  output logic [N_CACHES-1:0]        grant,
  output logic                       bus_valid,
  output logic [1:0]                 bus_op,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [SRC_W-1:0]           bus_src,
  output logic [N_CACHES-1:0]        done,
  output logic                       busy,
  output logic                       err
);

  typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_WB, S_DONE} state_e;

  localparam logic [1:0] OP_INV   = 2'b10;
  localparam logic [1:0] OP_EMPTY = 2'b11;

  state_e                state_q, state_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [N_CACHES-1:0]   ackAcc_q, ackAcc_d;
  logic [N_CACHES-1:0]   wbAcc_q, wbAcc_d;
  logic [N_CACHES-1:0]   grant_q, grant_d;
  logic                  busValid_q, busValid_d;
  logic [N_CACHES-1:0]   done_q, done_d;
  logic                  err_q, err_d;

  logic [N_CACHES-1:0]   eligible;
  logic                  found;
  logic [SRC_W-1:0]      selIdx;
  logic [N_CACHES-1:0]   ackNow, wbNow;
  logic                  allAcked, multiWb, protoErr;
  logic [SRC_W-1:0]      ptrNext;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      eligible[i] = req[i] && (req_op[2*i +: 2] != OP_EMPTY);
    end
  end

  // First eligible requester scanning upward from the round-robin pointer.
  always_comb begin
    found  = 1'b0;
    selIdx = '0;
    for (int k = 0; k < N_CACHES; k++) begin
      if (!found && eligible[(int'(ptr_q) + k) % N_CACHES]) begin
        found  = 1'b1;
        selIdx = SRC_W'((int'(ptr_q) + k) % N_CACHES);
      end
    end
  end

  // grant_q is one-hot on the owner, so it doubles as the mask of ignored bits.
  assign ackNow   = ackAcc_q | (snoop_ack & ~grant_q);
  assign wbNow    = wbAcc_q | (snoop_ack & snoop_wb & ~grant_q);
  assign allAcked = &(ackNow | grant_q);
  assign multiWb  = |(wbNow & (wbNow - 1'b1));
  assign protoErr = multiWb || ((|wbNow) && (op_q == OP_INV));
  assign ptrNext  = (src_q == SRC_W'(N_CACHES - 1)) ? '0 : src_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    src_d      = src_q;
    op_d       = op_q;
    addr_d     = addr_q;
    ackAcc_d   = ackAcc_q;
    wbAcc_d    = wbAcc_q;
    grant_d    = grant_q;
    busValid_d = 1'b0;
    done_d     = '0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          src_d      = selIdx;
          op_d       = req_op[2*selIdx +: 2];
          addr_d     = req_addr[ADDR_W*selIdx +: ADDR_W];
          grant_d    = N_CACHES'(1) << selIdx;
          busValid_d = 1'b1;
          state_d    = S_BCAST;
        end
      end
      S_BCAST: begin
        ackAcc_d = '0;
        wbAcc_d  = '0;
        state_d  = S_SNOOP;
      end
      S_SNOOP: begin
        ackAcc_d = ackNow;
        wbAcc_d  = wbNow;
        if (protoErr) err_d = 1'b1;
        if (allAcked) begin
          if ((|wbNow) && !protoErr) begin
            state_d = S_WB;
          end else begin
            state_d = S_DONE;
            done_d  = grant_q;
          end
        end
      end
      S_WB: begin
        if (wb_done) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end
      end
      S_DONE: begin
        grant_d = '0;
        ptr_d   = ptrNext;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      src_q      <= '0;
      op_q       <= OP_EMPTY;
      addr_q     <= '0;
      ackAcc_q   <= '0;
      wbAcc_q    <= '0;
      grant_q    <= '0;
      busValid_q <= 1'b0;
      done_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      src_q      <= src_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      ackAcc_q   <= ackAcc_d;
      wbAcc_q    <= wbAcc_d;
      grant_q    <= grant_d;
      busValid_q <= busValid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign grant     = grant_q;
  assign bus_valid = busValid_q;
  assign bus_op    = op_q;
  assign bus_addr  = addr_q;
  assign bus_src   = src_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level round-robin/snoop model.
module tb_snoop_bus_arbiter;

  localparam int N = 4;

  logic          clock;
  logic          reset;
  logic [N-1:0]  req;
  logic [2*N-1:0] req_op;
  logic [8*N-1:0] req_addr;
  logic [N-1:0]  snoop_ack;
  logic [N-1:0]  snoop_wb;
  logic          wb_done;
  logic [N-1:0]  grant;
  logic          bus_valid;
  logic [1:0]    bus_op;
  logic [7:0]    bus_addr;
  logic [1:0]    bus_src;
  logic [N-1:0]  done;
  logic          busy;
  logic          err;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int         bcastCycle;
    int         doneCycle;
    logic [3:0] grantAtBcast;
    logic [1:0] op;
    logic [7:0] addr;
    logic [1:0] src;
    logic [3:0] doneVal;
    logic [7:0] addrAtDone;
    logic       errAtDone;
    logic [3:0] grantAfter;
    bit         grantStable;
    bit         busyStable;
    bit         timedOut;
  } txnObs_t;

  snoop_bus_arbiter #(.N_CACHES(4), .ADDR_W(8), .SRC_W(2)) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .snoop_ack(snoop_ack), .snoop_wb(snoop_wb), .wb_done(wb_done),
    .grant(grant), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_src(bus_src), .done(done), .busy(busy), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    req = '0; req_op = '0; req_addr = '0;
    snoop_ack = '0; snoop_wb = '0; wb_done = 1'b0;
  endtask

  task automatic applyReset();
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives one bus transaction from the IDLE cycle onward and records what the DUT did.
  // ackAt[i] is the snoop-cycle offset at which cache i acks; wb_done comes wbDelay
  // cycles after the last non-source ack.
  task automatic runTxn(input int ackAt[4], input logic [3:0] wbMask, input int wbDelay,
                        input bit scramble, output txnObs_t o);
    bit seenB = 0;
    int snoopStart = 0;
    int lastAbs = 0;
    logic [3:0] bg = '0;
    o = '{bcastCycle: -1, doneCycle: -1, grantAtBcast: '0, op: '0, addr: '0, src: '0,
          doneVal: '0, addrAtDone: '0, errAtDone: 1'b0, grantAfter: '0,
          grantStable: 1, busyStable: 1, timedOut: 0};
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (!seenB && bus_valid) begin
        seenB = 1;
        o.bcastCycle = c; bg = grant; o.grantAtBcast = grant;
        o.op = bus_op; o.addr = bus_addr; o.src = bus_src;
        snoopStart = c + 1;
        lastAbs = snoopStart;
        for (int i = 0; i < N; i++)
          if (i != int'(bus_src) && snoopStart + ackAt[i] > lastAbs) lastAbs = snoopStart + ackAt[i];
        if (scramble) begin
          req_addr = $urandom;
          req[bus_src] = 1'b0;
        end
      end
      if (seenB) begin
        if (grant !== bg) o.grantStable = 0;
        if (busy !== 1'b1) o.busyStable = 0;
      end
      if (done !== '0) begin
        o.doneCycle = c; o.doneVal = done; o.addrAtDone = bus_addr; o.errAtDone = err;
        snoop_ack = '0; snoop_wb = '0; wb_done = 1'b0;
        tick();
        o.grantAfter = grant;
        return;
      end
      snoop_ack = '0; snoop_wb = '0; wb_done = 1'b0;
      if (seenB && c >= snoopStart) begin
        for (int i = 0; i < N; i++) begin
          if (c - snoopStart == ackAt[i]) begin
            snoop_ack[i] = 1'b1;
            snoop_wb[i]  = wbMask[i];
          end
        end
      end
      if (seenB && wbMask != '0 && c == lastAbs + wbDelay) wb_done = 1'b1;
    end
    o.timedOut = 1;
    snoop_ack = '0; snoop_wb = '0; wb_done = 1'b0;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b1;
    tick();
    checks++; if (grant !== 4'b0)     begin fails++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
    checks++; if (bus_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_bus_valid got %b want 0", bus_valid); end
    checks++; if (bus_op !== 2'b11)   begin fails++; $display("[TB] FAIL reset_bus_op got %b want 11", bus_op); end
    checks++; if (bus_addr !== 8'h00) begin fails++; $display("[TB] FAIL reset_bus_addr got %h want 00", bus_addr); end
    checks++; if (bus_src !== 2'd0)   begin fails++; $display("[TB] FAIL reset_bus_src got %0d want 0", bus_src); end
    checks++; if (done !== 4'b0)      begin fails++; $display("[TB] FAIL reset_done got %b want 0000", done); end
    checks++; if (busy !== 1'b0)      begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0)       begin fails++; $display("[TB] FAIL reset_err got %b want 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int acks[4];
    txnObs_t o;
    applyReset();
    acks = '{0, 0, 0, 0};
    req = 4'b0001; req_op = 8'h00; req_addr[7:0] = 8'h3C;
    runTxn(acks, 4'b0000, 1, 0, o);
    checks++; if (o.bcastCycle !== 1)        begin fails++; $display("[TB] FAIL single_bcast_cycle got %0d want 1", o.bcastCycle); end
    checks++; if (o.grantAtBcast !== 4'b0001) begin fails++; $display("[TB] FAIL single_grant got %b want 0001", o.grantAtBcast); end
    checks++; if (o.op !== 2'b00)            begin fails++; $display("[TB] FAIL single_op got %b want 00", o.op); end
    checks++; if (o.addr !== 8'h3C)          begin fails++; $display("[TB] FAIL single_addr got %h want 3c", o.addr); end
    checks++; if (o.src !== 2'd0)            begin fails++; $display("[TB] FAIL single_src got %0d want 0", o.src); end
    checks++; if (o.doneCycle !== 3)         begin fails++; $display("[TB] FAIL single_done_cycle got %0d want 3", o.doneCycle); end
    checks++; if (o.doneVal !== 4'b0001)     begin fails++; $display("[TB] FAIL single_done got %b want 0001", o.doneVal); end
    checks++; if (o.grantAfter !== 4'b0000)  begin fails++; $display("[TB] FAIL single_grant_after got %b want 0000", o.grantAfter); end
  endtask

  task automatic test_round_robin();
    int acks[4];
    txnObs_t o;
    logic [3:0] expG [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    applyReset();
    acks = '{0, 0, 0, 0};
    req = 4'b1111; req_op = 8'h00; req_addr = 32'h44332211;
    for (int t = 0; t < 5; t++) begin
      runTxn(acks, 4'b0000, 1, 0, o);
      checks++; if (o.grantAtBcast !== expG[t]) begin fails++; $display("[TB] FAIL rr_grant[%0d] got %b want %b", t, o.grantAtBcast, expG[t]); end
      checks++; if (o.bcastCycle !== 1 || o.doneCycle !== 3 || !o.grantStable)
        begin fails++; $display("[TB] FAIL rr_timing[%0d] got bcast %0d done %0d stable %0d want 1 3 1", t, o.bcastCycle, o.doneCycle, o.grantStable); end
    end
  endtask

  task automatic test_writeback();
    int acks[4];
    txnObs_t o;
    applyReset();
    acks = '{0, 0, 0, 0};
    req = 4'b0100; req_op[5:4] = 2'b01; req_addr[23:16] = 8'h10;
    runTxn(acks, 4'b0001, 4, 0, o);
    checks++; if (o.grantAtBcast !== 4'b0100) begin fails++; $display("[TB] FAIL wb_grant got %b want 0100", o.grantAtBcast); end
    checks++; if (o.doneCycle !== 7)          begin fails++; $display("[TB] FAIL wb_done_cycle got %0d want 7", o.doneCycle); end
    checks++; if (o.doneVal !== 4'b0100)      begin fails++; $display("[TB] FAIL wb_done got %b want 0100", o.doneVal); end
    checks++; if (o.errAtDone !== 1'b0)       begin fails++; $display("[TB] FAIL wb_err got %b want 0", o.errAtDone); end
    checks++; if (!o.busyStable)              begin fails++; $display("[TB] FAIL wb_busy got dropped want held"); end
  endtask

  task automatic test_invalidate_err();
    int acks[4];
    txnObs_t o;
    applyReset();
    acks = '{0, 0, 0, 0};
    req = 4'b0010; req_op[3:2] = 2'b10; req_addr[15:8] = 8'h55;
    runTxn(acks, 4'b1000, 2, 0, o);
    checks++; if (o.doneCycle !== 3)     begin fails++; $display("[TB] FAIL inv_done_cycle got %0d want 3", o.doneCycle); end
    checks++; if (o.doneVal !== 4'b0010) begin fails++; $display("[TB] FAIL inv_done got %b want 0010", o.doneVal); end
    checks++; if (o.errAtDone !== 1'b1)  begin fails++; $display("[TB] FAIL inv_err got %b want 1", o.errAtDone); end
    req = 4'b0001; req_op = 8'h00;
    runTxn(acks, 4'b0000, 1, 0, o);
    checks++; if (err !== 1'b1)          begin fails++; $display("[TB] FAIL inv_err_sticky got %b want 1", err); end
  endtask

  task automatic test_delayed_ack();
    int acks[4];
    txnObs_t o;
    applyReset();
    acks = '{0, 0, 0, 5};
    req = 4'b0001; req_op = 8'h00; req_addr[7:0] = 8'hA7;
    runTxn(acks, 4'b0000, 1, 0, o);
    checks++; if (o.doneCycle !== 8)  begin fails++; $display("[TB] FAIL delay_done_cycle got %0d want 8", o.doneCycle); end
    checks++; if (!o.grantStable)     begin fails++; $display("[TB] FAIL delay_grant_held got unstable want stable"); end
  endtask

  task automatic test_empty_op_and_reset();
    int acks[4];
    txnObs_t o;
    bit anyGrant = 0;
    applyReset();
    req = 4'b1111; req_op = 8'hFF;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (grant !== 4'b0 || busy !== 1'b0 || bus_valid !== 1'b0) anyGrant = 1;
    end
    checks++; if (anyGrant) begin fails++; $display("[TB] FAIL empty_op got activity want no grant"); end
    acks = '{0, 0, 0, 0};
    req = 4'b0010; req_op = 8'h00;
    runTxn(acks, 4'b0000, 1, 0, o);
    req = 4'b0100;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0000;
    checks++; if (grant !== 4'b0 || bus_valid !== 1'b0 || bus_op !== 2'b11 || bus_addr !== 8'h00 ||
                  bus_src !== 2'd0 || done !== 4'b0 || busy !== 1'b0 || err !== 1'b0)
      begin fails++; $display("[TB] FAIL midreset_outputs got g=%b v=%b op=%b a=%h s=%0d d=%b b=%b e=%b", grant, bus_valid, bus_op, bus_addr, bus_src, done, busy, err); end
    tick();
    checks++; if (done !== 4'b0) begin fails++; $display("[TB] FAIL midreset_no_done got %b want 0000", done); end
    req = 4'b1111;
    runTxn(acks, 4'b0000, 1, 0, o);
    checks++; if (o.grantAtBcast !== 4'b0001) begin fails++; $display("[TB] FAIL midreset_ptr got %b want 0001", o.grantAtBcast); end
  endtask

  task automatic test_random();
    int acks[4];
    txnObs_t o;
    int modelPtr = 0;
    bit errSticky = 0;
    applyReset();
    for (int it = 0; it < 40; it++) begin
      int w = -1;
      logic [1:0] ops[4];
      logic [7:0] addrs[4];
      logic [3:0] mask, wbMask, srcBit;
      int wbDelay, wbCount, lastRel, expDone;
      bit errExp, wbPath, scr;
      mask = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        ops[i] = 2'($urandom_range(0, 3));
        addrs[i] = 8'($urandom);
        req_op[2*i +: 2] = ops[i];
        req_addr[8*i +: 8] = addrs[i];
      end
      req = mask;
      for (int k = 0; k < N; k++)
        if (w < 0 && mask[(modelPtr + k) % N] && ops[(modelPtr + k) % N] != 2'b11) w = (modelPtr + k) % N;
      if (w < 0) begin
        tick(); tick(); tick();
        checks++; if (grant !== 4'b0 || busy !== 1'b0)
          begin fails++; $display("[TB] FAIL rand_idle[%0d] got grant %b busy %b want 0000 0", it, grant, busy); end
        continue;
      end
      for (int i = 0; i < N; i++) acks[i] = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       wbMask = 4'b0001 << $urandom_range(0, 3);
        1:       wbMask = (4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3));
        default: wbMask = 4'b0000;
      endcase
      wbDelay = $urandom_range(1, 4);
      scr = 1'($urandom_range(0, 1));
      srcBit = 4'b0001 << w;
      wbCount = $countones(wbMask & ~srcBit);
      errExp = (wbCount >= 2) || (wbCount >= 1 && ops[w] == 2'b10);
      wbPath = (wbCount >= 1) && !errExp;
      errSticky = errSticky || errExp;
      lastRel = 0;
      for (int i = 0; i < N; i++) if (i != w && acks[i] > lastRel) lastRel = acks[i];
      expDone = 2 + lastRel + (wbPath ? wbDelay + 1 : 1);
      runTxn(acks, wbMask, wbDelay, scr, o);
      checks++; if (o.timedOut) begin fails++; $display("[TB] FAIL rand_timeout[%0d] got no done want done", it); end
      checks++; if (o.grantAtBcast !== srcBit || o.src !== 2'(w))
        begin fails++; $display("[TB] FAIL rand_grant[%0d] got %b/%0d want %b/%0d", it, o.grantAtBcast, o.src, srcBit, w); end
      checks++; if (o.op !== ops[w] || o.addr !== addrs[w] || o.addrAtDone !== addrs[w])
        begin fails++; $display("[TB] FAIL rand_payload[%0d] got %b %h %h want %b %h", it, o.op, o.addr, o.addrAtDone, ops[w], addrs[w]); end
      checks++; if (o.doneCycle !== expDone || o.doneVal !== srcBit)
        begin fails++; $display("[TB] FAIL rand_done[%0d] got cyc %0d val %b want cyc %0d val %b", it, o.doneCycle, o.doneVal, expDone, srcBit); end
      checks++; if (o.errAtDone !== errSticky)
        begin fails++; $display("[TB] FAIL rand_err[%0d] got %b want %b", it, o.errAtDone, errSticky); end
      checks++; if (o.grantAfter !== 4'b0 || !o.grantStable)
        begin fails++; $display("[TB] FAIL rand_grant_release[%0d] got after %b stable %0d want 0000 1", it, o.grantAfter, o.grantStable); end
      modelPtr = (w + 1) % N;
    end
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_writeback();
    test_invalidate_err();
    test_delayed_ack();
    test_empty_op_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shared-bus controller for the snooping MSI coherence system.
- Takes bus requests from N per-cache processor-side controllers (read miss, write miss and invalidate messages) and grants the bus round-robin to one requester.
- Broadcasts the granted transaction to all caches, collects snoop acknowledgements and sequences an optional write-back from the cache holding the block exclusive.
- Signals completion to the requester. Exactly one bus transaction is in flight at a time.

Parameters:
- N_CACHES, 4, number of caches on the bus (1..8).
- ADDR_W, 8, block address width.
- SRC_W, 2, width of the source index; must be ≥ clog2(N_CACHES), 1 when N_CACHES=1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_CACHES  per-cache bus request, level.
- req_op  in  2*N_CACHES  per-cache message; cache i uses bits [2i+1:2i]. 00 PlaceReadMissOnBus, 01 PlaceWriteMissOnBus, 10 PlaceInvalidateOnBus, 11 EmptyMessage.
- req_addr  in  ADDR_W*N_CACHES  per-cache block address; cache i uses slice i.
- snoop_ack  in  N_CACHES  per-cache "snoop processed".
- snoop_wb  in  N_CACHES  per-cache "I hold the block exclusive, write-back required"; valid only together with snoop_ack.
- wb_done  in  1  memory reports write-back finished.
- grant  out  N_CACHES  one-hot bus owner.
- bus_valid  out  1  one-cycle broadcast strobe.
- bus_op  out  2  broadcast message.
- bus_addr  out  ADDR_W  broadcast address.
- bus_src  out  SRC_W  index of the owner.
- done  out  N_CACHES  one-cycle completion pulse to the owner.
- busy  out  1  transaction in flight, i.e. state ≠ IDLE.
- err  out  1  sticky protocol error.

Behaviour:
- All outputs are registered. On reset:
  - grant=0, bus_valid=0, bus_op=11, bus_addr=0, bus_src=0, done=0, busy=0, err=0.
  - State goes to IDLE and the round-robin pointer to 0.
  - Reset mid-transaction abandons the transaction with no done pulse.
- Eligible request: req[i]=1 and req_op slice ≠ 11. An op of 11 is ignored even with req high.
- IDLE:
  - If any request is eligible, choose the first eligible index scanning ptr, ptr+1, … modulo N_CACHES.
  - Latch its op and address, and record the source index s.
  - Go to BCAST.
- BCAST (1 cycle):
  - grant[s]=1, bus_valid=1, bus_op/bus_addr/bus_src driven from the latched values.
  - Clear the ack/wb accumulators.
  - Go to SNOOP.
- SNOOP:
  - grant held; bus_valid=0; bus_op/bus_addr/bus_src are held until DONE.
  - Each cycle, OR snoop_ack and snoop_ack&snoop_wb into the accumulators.
  - Bit s is always ignored, and acks during BCAST are ignored.
  - When every non-source bit is accumulated (including the current cycle), the next state is:
    - WB if any wb bit is accumulated and op ≠ 10;
    - DONE otherwise.
  - N_CACHES=1 leaves SNOOP after exactly one cycle.
- WB: wait for wb_done=1, then go to DONE. wb_done outside WB is ignored.
- DONE (1 cycle):
  - done[s]=1.
  - Next cycle: grant=0, done=0, ptr=(s+1) mod N_CACHES, state IDLE.
- Minimum latency: request seen in IDLE at edge 0 → bus_valid in cycle 1 → SNOOP from cycle 2 → done in cycle 3.
  - A new grant cannot start before the cycle after DONE.
- The requester dropping req after the grant does not abort the transaction; latched values are used.
- err is set (sticky until reset) when, in SNOOP:
  - two or more distinct non-source wb bits are accumulated, or
  - any wb bit is seen with op=10 (invalidate).
  - The transaction still completes and skips WB.
- Simultaneous requests: exactly one grant is issued; losers keep their req and are served in rotation, with no starvation (each waits at most N_CACHES-1 transactions).

Test Plan:
1. Reset, then req=0001, op0=00, addr0=0x3C, all other caches ack in cycle 2 → grant=0001 and bus_valid/bus_op=00/bus_addr=0x3C/bus_src=0 in cycle 1, done=0001 in cycle 3, grant=0 in cycle 4.
2. req=1111 held, ops=00, acks immediate → grants in order 0001, 0010, 0100, 1000, 0001; each grant lasts 3 cycles with 1 idle cycle between.
3. Cache 2 write miss (op 01, addr 0x10); cache 0 returns ack+wb in cycle 2; wb_done raised 4 cycles later → state WB, done=0100 the cycle after wb_done, err=0.
4. Cache 1 invalidate (op 10) with cache 3 asserting wb → err=1 and stays 1, no WB state, done=0010 still issued.
5. Cache 0 read miss; cache 3 acks only after a 5-cycle delay → grant held for the whole delay, done exactly 1 cycle after the last ack.
6. req with op=11 → no grant. Reset asserted during SNOOP → next cycle all outputs at their reset values, no done pulse, ptr=0.
